rom_prefetch_queue: RTL and testbench

Instruction-byte prefetcher sitting between the CPU decode stage and the 16KB program ROM, which is mapped at $C000-$FFFF. On reset it reads the RESET vector at $FFFC/$FFFD. It then streams sequential ROM bytes into a small FIFO, tagging each byte with its 16-bit address. The CPU pops bytes with a valid/ready handshake and redirects fetch (JMP/JSR/branch/RTS) with a flush.

---
 rtl/rom_prefetch_queue.sv | 178 +++++++++++++++++
 tb/tb_rom_prefetch_queue.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rom_prefetch_queue.sv
// rom_prefetch_queue
//   Instruction-byte prefetcher between the CPU decode stage and the program
//   ROM, which sits at the top of the 64KB space. After reset it reads the
//   RESET vector, then streams sequential ROM bytes into a small FIFO. Each
//   byte is tagged with its 16-bit address. The consumer pops the head with a
//   valid/ready handshake and redirects fetch with flush/flush_pc.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   rom_addr/cs/oe        ROM read port (oe always mirrors cs)
//   rom_data              combinational ROM read data, only sampled under cs
//   flush, flush_pc       drop the queue and restart fetch at flush_pc
//   out_valid/data/pc     queue head and its address
//   out_ready             consumer accepts the head this cycle
//   fetch_fault           sticky: fetch PC left the ROM window
module rom_prefetch_queue #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_cs,
  output logic                  rom_oe,
  input  logic [DATA_WIDTH-1:0] rom_data,
  input  logic                  flush,
  input  logic [15:0]           flush_pc,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [15:0]           out_pc,
  input  logic                  out_ready,
  output logic                  fetch_fault
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [15:0] VEC_LO_ADDR = 16'hFFFC;
  localparam logic [15:0] VEC_HI_ADDR = 16'hFFFD;

  typedef enum logic [1:0] {
    VEC_LO,
    VEC_HI,
    FETCH,
    HALT
  } state_e;

  state_e                state_q, state_d;
  logic [15:0]           fetch_pc_q, fetch_pc_d;
  logic [DATA_WIDTH-1:0] vec_lo_q, vec_lo_d;
  logic                  fault_q, fault_d;
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;

  logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
  logic [15:0]           pc_mem_q   [DEPTH];

  logic in_range;
  logic pop;
  logic push;

  // The ROM occupies the top 2^ADDR_WIDTH bytes, so every bit above the ROM
  // address field must be set.
  assign in_range = &fetch_pc_q[15:ADDR_WIDTH];

  assign out_valid   = (count_q != '0);
  assign pop         = out_valid & out_ready;
  assign out_data    = data_mem_q[rd_ptr_q];
  assign out_pc      = pc_mem_q[rd_ptr_q];
  assign fetch_fault = fault_q;
  assign rom_oe      = rom_cs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= VEC_LO;
      fetch_pc_q <= VEC_LO_ADDR;
      vec_lo_q   <= '0;
      fault_q    <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      vec_lo_q   <= vec_lo_d;
      fault_q    <= fault_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only visible once count covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= rom_data;
      pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
    end
  end

  // Fetch sequencer. rom_cs doubles as the push strobe in FETCH, so rom_data
  // is never captured while the ROM is deselected (and possibly floating).
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    vec_lo_d   = vec_lo_q;
    fault_d    = fault_q;
    rom_cs     = 1'b0;
    rom_addr   = fetch_pc_q[ADDR_WIDTH-1:0];
    push       = 1'b0;

    if (flush) begin
      state_d    = FETCH;
      fetch_pc_d = flush_pc;
      fault_d    = 1'b0;
    end else begin
      unique case (state_q)
        VEC_LO: begin
          rom_cs   = 1'b1;
          rom_addr = VEC_LO_ADDR[ADDR_WIDTH-1:0];
          vec_lo_d = rom_data;
          state_d  = VEC_HI;
        end
        VEC_HI: begin
          rom_cs     = 1'b1;
          rom_addr   = VEC_HI_ADDR[ADDR_WIDTH-1:0];
          fetch_pc_d = 16'({rom_data, vec_lo_q});
          state_d    = FETCH;
        end
        FETCH: begin
          if (!in_range) begin
            fault_d = 1'b1;
            state_d = HALT;
          end else if ((count_q < DEPTH_C) || pop) begin
            rom_cs     = 1'b1;
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 16'd1;
          end
        end
        HALT: begin
          // Queue keeps draining; only flush restarts fetch.
        end
        default: begin
          state_d = HALT;
        end
      endcase
    end
  end

  // FIFO bookkeeping. Simultaneous push and pop keep count steady, which is
  // what lets a full queue stream one byte per cycle.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_rom_prefetch_queue.sv
// tb_rom_prefetch_queue
//   Directed bench for rom_prefetch_queue. A behavioural ROM drives rom_data
//   only while cs&oe are high and floats it otherwise. Inputs change and
//   outputs are sampled on the falling clock edge; the DUT acts on the rising
//   edge.
module tb_rom_prefetch_queue;

  logic        clk;
  logic        rst_n;
  logic [13:0] rom_addr;
  logic        rom_cs;
  logic        rom_oe;
  wire  [7:0]  rom_data;
  logic        flush;
  logic [15:0] flush_pc;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [15:0] out_pc;
  logic        out_ready;
  logic        fetch_fault;

  int compareCount;
  int mismatchCount;

  logic [7:0] rom [16384];

  logic [7:0] streamBytes [8];

  rom_prefetch_queue #(
    .DEPTH(4),
    .ADDR_WIDTH(14),
    .DATA_WIDTH(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rom_addr   (rom_addr),
    .rom_cs     (rom_cs),
    .rom_oe     (rom_oe),
    .rom_data   (rom_data),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_pc     (out_pc),
    .out_ready  (out_ready),
    .fetch_fault(fetch_fault)
  );

  assign rom_data = (rom_cs && rom_oe) ? rom[rom_addr] : 8'hzz;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish expected finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic f, input logic [15:0] fpc,
                               input logic rdy);
    flush     = f;
    flush_pc  = fpc;
    out_ready = rdy;
  endtask

  task automatic checkHead(input string tag, input logic [15:0] pc,
                           input logic [7:0] data);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_pc"}, 32'(out_pc), 32'(pc));
    checkOutput({tag, "_data"}, 32'(out_data), 32'(data));
  endtask

  // Hold reset for two cycles, then release it on a falling edge.
  task automatic doReset(input logic rdy);
    rst_n = 1'b0;
    applyStimulus(1'b0, 16'h0000, rdy);
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_fault", 32'(fetch_fault), 32'd0);
    checkOutput("rst_addr", 32'(rom_addr), 32'h3FFC);
    rst_n = 1'b1;
  endtask

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    rst_n = 1'b0;
    applyStimulus(1'b0, 16'h0000, 1'b0);

    for (int i = 0; i < 16384; i++) rom[i] = 8'hEA;
    rom[14'h3FFC] = 8'h00;
    rom[14'h3FFD] = 8'hC0;
    rom[14'h0000] = 8'h18;
    rom[14'h0001] = 8'hA9;
    rom[14'h0002] = 8'h0A;
    rom[14'h0003] = 8'h8D;
    rom[14'h0004] = 8'h00;
    rom[14'h0005] = 8'h02;
    rom[14'h0006] = 8'h4C;
    rom[14'h0007] = 8'h00;
    rom[14'h0020] = 8'hA9;
    rom[14'h0021] = 8'h00;
    rom[14'h0022] = 8'h85;
    rom[14'h3FFE] = 8'h00;
    rom[14'h3FFF] = 8'hF8;
    rom[14'h0100] = 8'hAD;

    streamBytes[0] = 8'h18; streamBytes[1] = 8'hA9;
    streamBytes[2] = 8'h0A; streamBytes[3] = 8'h8D;
    streamBytes[4] = 8'h00; streamBytes[5] = 8'h02;
    streamBytes[6] = 8'h4C; streamBytes[7] = 8'h00;

    // Vector fetch and first three bytes with the consumer always ready.
    @(negedge clk);
    doReset(1'b1);
    @(negedge clk);
    checkOutput("vec1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    checkOutput("vec2_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    checkHead("pop0", 16'hC000, 8'h18);
    @(negedge clk);
    checkHead("pop1", 16'hC001, 8'hA9);
    @(negedge clk);
    checkHead("pop2", 16'hC002, 8'h0A);

    // Backpressure: fill to DEPTH, then stream out with no gaps or repeats.
    @(negedge clk);
    doReset(1'b0);
    repeat (8) @(negedge clk);
    checkHead("full_head", 16'hC000, 8'h18);
    checkOutput("full_cs", 32'(rom_cs), 32'd0);
    checkOutput("full_addr", 32'(rom_addr), 32'h0004);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    #1;
    checkOutput("full_pop_cs", 32'(rom_cs), 32'd1);
    for (int i = 0; i < 8; i++) begin
      checkHead($sformatf("stream%0d", i), 16'hC000 + 16'(i), streamBytes[i]);
      @(negedge clk);
    end

    // Flush with three stale bytes queued.
    doReset(1'b0);
    repeat (5) @(negedge clk);
    checkHead("pre_flush", 16'hC000, 8'h18);
    applyStimulus(1'b1, 16'hC020, 1'b0);
    #1;
    checkOutput("flush_cs", 32'(rom_cs), 32'd0);
    @(negedge clk);
    checkOutput("flush_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    @(negedge clk);
    checkHead("fl0", 16'hC020, 8'hA9);
    @(negedge clk);
    checkHead("fl1", 16'hC021, 8'h00);
    @(negedge clk);
    checkHead("fl2", 16'hC022, 8'h85);

    // Run off the top of the ROM into HALT.
    applyStimulus(1'b1, 16'hFFFE, 1'b1);
    @(negedge clk);
    checkOutput("top_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    @(negedge clk);
    checkHead("top0", 16'hFFFE, 8'h00);
    @(negedge clk);
    checkHead("top1", 16'hFFFF, 8'hF8);
    checkOutput("top1_fault", 32'(fetch_fault), 32'd0);
    checkOutput("wrap_cs", 32'(rom_cs), 32'd0);
    @(negedge clk);
    checkOutput("halt_valid", 32'(out_valid), 32'd0);
    checkOutput("halt_fault", 32'(fetch_fault), 32'd1);
    checkOutput("halt_cs", 32'(rom_cs), 32'd0);
    @(negedge clk);
    checkOutput("halt2_fault", 32'(fetch_fault), 32'd1);
    checkOutput("halt2_cs", 32'(rom_cs), 32'd0);
    applyStimulus(1'b1, 16'hC100, 1'b1);
    @(negedge clk);
    checkOutput("clr_fault", 32'(fetch_fault), 32'd0);
    checkOutput("clr_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    @(negedge clk);
    checkHead("c100", 16'hC100, 8'hAD);

    // Flush straight to an address outside the ROM.
    applyStimulus(1'b1, 16'h8000, 1'b1);
    #1;
    checkOutput("oor_flush_cs", 32'(rom_cs), 32'd0);
    @(negedge clk);
    checkOutput("oor_fault0", 32'(fetch_fault), 32'd0);
    checkOutput("oor_valid0", 32'(out_valid), 32'd0);
    checkOutput("oor_cs0", 32'(rom_cs), 32'd0);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    @(negedge clk);
    checkOutput("oor_fault1", 32'(fetch_fault), 32'd1);
    checkOutput("oor_valid1", 32'(out_valid), 32'd0);
    checkOutput("oor_cs1", 32'(rom_cs), 32'd0);

    // Asynchronous reset while two bytes are queued.
    doReset(1'b0);
    repeat (4) @(negedge clk);
    checkHead("mid_head", 16'hC000, 8'h18);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 16'h0000, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("re_vec_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    checkHead("re_pop0", 16'hC000, 8'h18);
    @(negedge clk);
    checkHead("re_pop1", 16'hC001, 8'hA9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount,
             mismatchCount);
    $finish;
  end

endmodule
